// File: rtl/cv32e40p_pkg.sv
// Shared types for the IF/ID instruction queue.
package cv32e40p_pkg;

  // One decoded-fetch entry; all fields move together through the queue.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        compressed;
    logic        illegal_c;
    logic        fetch_failed;
  } if_id_entry_t;

endpackage

// File: rtl/cv32e40p_if_id_queue.sv
// IF/ID instruction queue: a small circular buffer of fetched instructions
// between the aligner/decompressor and the ID stage.
// Optional macro CV32E40P_IFQ_BYPASS_EN: a push into an empty queue is
// presented to ID in the same cycle (and consumed without being stored when
// ID is ready). Without it the queue is a pure registered path.
//
// Handshake: a push happens when in_valid_i & in_ready_o are both high (and
// neither halt_i nor flush_i is set); a pop happens when instr_valid_id_o &
// id_ready_i are both high (and flush_i is low). in_ready_o depends only on
// the current occupancy, never on same-cycle pops.
module cv32e40p_if_id_queue
  import cv32e40p_pkg::*;
#(
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned COUNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush_i,
  input  logic               halt_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [31:0]        in_instr_i,
  input  logic [31:0]        in_pc_i,
  input  logic               in_compressed_i,
  input  logic               in_illegal_c_i,
  input  logic               in_fetch_failed_i,
  output logic               instr_valid_id_o,
  input  logic               id_ready_i,
  output logic [31:0]        instr_rdata_id_o,
  output logic [31:0]        pc_id_o,
  output logic               is_compressed_id_o,
  output logic               illegal_c_insn_id_o,
  output logic               is_fetch_failed_o,
  output logic [COUNT_W-1:0] count_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam int unsigned        PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0]   LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [COUNT_W-1:0] FULL_CNT = COUNT_W'(DEPTH);

  if_id_entry_t       r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wptr;
  logic [PTR_W-1:0]   r_rptr;
  logic [COUNT_W-1:0] r_count;

  if_id_entry_t w_in;
  if_id_entry_t w_head;
  if_id_entry_t w_out;
  logic         w_full;
  logic         w_empty;
  logic         w_push;
  logic         w_pop;
  logic         w_bypass;
  logic         w_store;
  logic         w_unload;

  // Explicit wrap so non-power-of-two depths never alias a slot.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_in    = {in_instr_i, in_pc_i, in_compressed_i, in_illegal_c_i, in_fetch_failed_i};
  assign w_head  = r_mem[r_rptr];
  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  assign w_push  = in_valid_i & ~w_full & ~halt_i & ~flush_i;

`ifdef CV32E40P_IFQ_BYPASS_EN
  assign w_bypass = w_empty & w_push;
`else
  assign w_bypass = 1'b0;
`endif

  assign instr_valid_id_o = ~w_empty | w_bypass;
  assign w_out            = w_bypass ? w_in : w_head;
  assign w_pop            = instr_valid_id_o & id_ready_i & ~flush_i;
  // A bypassed entry that ID takes right away never enters storage.
  assign w_store          = w_push & ~(w_bypass & w_pop);
  assign w_unload         = w_pop & ~w_empty;

  assign in_ready_o          = ~w_full;
  assign full_o              = w_full;
  assign empty_o             = w_empty;
  assign count_o             = r_count;
  assign instr_rdata_id_o    = w_out.instr;
  assign pc_id_o             = w_out.pc;
  assign is_compressed_id_o  = w_out.compressed;
  assign illegal_c_insn_id_o = w_out.illegal_c;
  assign is_fetch_failed_o   = w_out.fetch_failed;

  // Storage, pointers and occupancy; flush drops validity but keeps contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (flush_i) begin
      r_rptr  <= r_wptr;
      r_count <= '0;
    end else begin
      if (w_store) begin
        r_mem[r_wptr] <= w_in;
        r_wptr        <= ptr_inc(r_wptr);
      end
      if (w_unload) begin
        r_rptr <= ptr_inc(r_rptr);
      end
      if (w_store && !w_unload) begin
        r_count <= r_count + COUNT_W'(1);
      end else if (!w_store && w_unload) begin
        r_count <= r_count - COUNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_cv32e40p_if_id_queue.sv
// Bench for the IF/ID queue: two instances (DEPTH=2 and DEPTH=3) share one
// stimulus stream; each is compared against a queue-based reference model.
module tb_cv32e40p_if_id_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush_i, halt_i, in_valid_i, id_ready_i;
  logic [31:0] in_instr_i, in_pc_i;
  logic        in_compressed_i, in_illegal_c_i, in_fetch_failed_i;

  logic        rdy   [2];
  logic        vld   [2];
  logic [31:0] instr [2];
  logic [31:0] pc    [2];
  logic        cflag [2];
  logic        iflag [2];
  logic        fflag [2];
  logic [1:0]  cnt   [2];
  logic        full  [2];
  logic        empty [2];

  int n_checks = 0;
  int n_errors = 0;

  logic [66:0] mq0[$];
  logic [66:0] mq1[$];
  logic [66:0] popped3[$];

  // clock
  always #5 clk = ~clk;

  cv32e40p_if_id_queue #(.DEPTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .halt_i(halt_i),
    .in_valid_i(in_valid_i), .in_ready_o(rdy[0]), .in_instr_i(in_instr_i),
    .in_pc_i(in_pc_i), .in_compressed_i(in_compressed_i),
    .in_illegal_c_i(in_illegal_c_i), .in_fetch_failed_i(in_fetch_failed_i),
    .instr_valid_id_o(vld[0]), .id_ready_i(id_ready_i),
    .instr_rdata_id_o(instr[0]), .pc_id_o(pc[0]),
    .is_compressed_id_o(cflag[0]), .illegal_c_insn_id_o(iflag[0]),
    .is_fetch_failed_o(fflag[0]), .count_o(cnt[0]), .full_o(full[0]),
    .empty_o(empty[0])
  );

  cv32e40p_if_id_queue #(.DEPTH(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .halt_i(halt_i),
    .in_valid_i(in_valid_i), .in_ready_o(rdy[1]), .in_instr_i(in_instr_i),
    .in_pc_i(in_pc_i), .in_compressed_i(in_compressed_i),
    .in_illegal_c_i(in_illegal_c_i), .in_fetch_failed_i(in_fetch_failed_i),
    .instr_valid_id_o(vld[1]), .id_ready_i(id_ready_i),
    .instr_rdata_id_o(instr[1]), .pc_id_o(pc[1]),
    .is_compressed_id_o(cflag[1]), .illegal_c_insn_id_o(iflag[1]),
    .is_fetch_failed_o(fflag[1]), .count_o(cnt[1]), .full_o(full[1]),
    .empty_o(empty[1])
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    in_valid_i = 1'b0; flush_i = 1'b0; halt_i = 1'b0; id_ready_i = 1'b0;
    in_instr_i = '0; in_pc_i = '0;
    in_compressed_i = 1'b0; in_illegal_c_i = 1'b0; in_fetch_failed_i = 1'b0;
  endtask

  // Asynchronous reset: outputs must clear without waiting for a clock edge.
  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst_ready%0d", k), rdy[k], 1);
      check($sformatf("rst_valid%0d", k), vld[k], 0);
      check($sformatf("rst_count%0d", k), cnt[k], 0);
      check($sformatf("rst_full%0d", k), full[k], 0);
      check($sformatf("rst_empty%0d", k), empty[k], 1);
      check($sformatf("rst_data%0d", k),
            {instr[k], pc[k], cflag[k], iflag[k], fflag[k]}, 0);
    end
    mq0.delete();
    mq1.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Compare both DUTs with the model for the current inputs, then advance one clock.
  task automatic step();
    logic [66:0] in_e;
    in_e = {in_instr_i, in_pc_i, in_compressed_i, in_illegal_c_i, in_fetch_failed_i};
    #1;
    for (int k = 0; k < 2; k++) begin
      logic [66:0] q[$];
      logic [66:0] head;
      int dep;
      bit byp, mv, push, pop;
      if (k == 0) begin q = mq0; dep = 2; end
      else begin q = mq1; dep = 3; end
      byp = 1'b0;
`ifdef CV32E40P_IFQ_BYPASS_EN
      byp = (q.size() == 0) && in_valid_i && !halt_i && !flush_i;
`endif
      mv   = (q.size() > 0) || byp;
      head = (q.size() > 0) ? q[0] : in_e;
      push = in_valid_i && (q.size() < dep) && !halt_i && !flush_i;
      pop  = mv && id_ready_i && !flush_i;
      check($sformatf("ready_d%0d", dep), rdy[k], (q.size() < dep));
      check($sformatf("valid_d%0d", dep), vld[k], mv);
      check($sformatf("count_d%0d", dep), cnt[k], q.size());
      check($sformatf("full_d%0d", dep), full[k], (q.size() == dep));
      check($sformatf("empty_d%0d", dep), empty[k], (q.size() == 0));
      if (mv) check($sformatf("head_d%0d", dep),
                    {instr[k], pc[k], cflag[k], iflag[k], fflag[k]}, head);
      if (flush_i) q.delete();
      else begin
        if (push) q.push_back(in_e);
        if (pop) begin
          if (k == 1) popped3.push_back(q[0]);
          void'(q.pop_front());
        end
      end
      if (k == 0) mq0 = q; else mq1 = q;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_pc(input logic [31:0] p);
    in_valid_i = 1'b1; in_pc_i = p; in_instr_i = $urandom;
    in_compressed_i = 1'($urandom_range(0, 1));
    in_illegal_c_i = 1'($urandom_range(0, 1));
    in_fetch_failed_i = 1'($urandom_range(0, 1));
  endtask

  task automatic flush_cycle();
    idle_inputs(); flush_i = 1'b1; step(); flush_i = 1'b0;
  endtask

  initial begin
    idle_inputs();
    do_reset();

    // first push becomes visible next cycle
    push_pc(32'h80); in_instr_i = 32'h0000_0013; step();
    idle_inputs(); #1;
    check("first_valid", vld[0], 1);
    check("first_pc", pc[0], 32'h80);
    check("first_instr", instr[0], 32'h13);
    check("first_count", cnt[0], 1);
    step();

    // fill to full, third entry held until a pop frees a slot
    flush_cycle();
    push_pc(32'h200); step();
    push_pc(32'h204); step();
    check("full_ready", rdy[0], 0);
    check("full_flag", full[0], 1);
    push_pc(32'h208); step();
    check("held_count", cnt[0], 2);
    id_ready_i = 1'b1; step();
    id_ready_i = 1'b0; step();
    idle_inputs(); #1;
    check("held_accepted", cnt[0], 2);
    step();

    // flush with a concurrent push discards everything
    push_pc(32'h400); flush_i = 1'b1; step();
    idle_inputs(); #1;
    check("flush_count", cnt[0], 0);
    check("flush_valid", vld[0], 0);
    step();

    // halt blocks push but the queue still drains
    push_pc(32'h500); step();
    push_pc(32'h504); step();
    push_pc(32'h508); halt_i = 1'b1; id_ready_i = 1'b1;
    step(); step();
    idle_inputs(); #1;
    check("halt_empty2", empty[0], 1);
    check("halt_empty3", empty[1], 1);
    step();

    // ordered stream of 10 entries through the DEPTH=3 instance
    begin
      int idx = 0;
      int cyc = 0;
      flush_cycle();
      popped3.delete();
      while (popped3.size() < 10 && cyc < 200) begin
        bit acc;
        if (idx < 10) push_pc(32'(idx * 4)); else in_valid_i = 1'b0;
        id_ready_i = 1'($urandom_range(0, 1));
        acc = (idx < 10) && rdy[1];
        step();
        if (acc) idx++;
        cyc++;
      end
      check("stream_done", popped3.size(), 10);
      for (int i = 0; i < 10 && i < popped3.size(); i++)
        check($sformatf("stream_pc%0d", i), popped3[i][34:3], 32'(i * 4));
    end

`ifdef CV32E40P_IFQ_BYPASS_EN
    // bypass: empty queue, consumed in the same cycle, nothing stored
    flush_cycle();
    push_pc(32'h100); id_ready_i = 1'b1; #1;
    check("byp_valid", vld[0], 1);
    check("byp_pc", pc[0], 32'h100);
    step();
    idle_inputs(); #1;
    check("byp_count", cnt[0], 0);
`endif

    // random traffic
    for (int n = 0; n < 300; n++) begin
      push_pc($urandom);
      in_valid_i = 1'($urandom_range(0, 1));
      halt_i     = ($urandom_range(0, 3) == 0);
      flush_i    = ($urandom_range(0, 15) == 0);
      id_ready_i = 1'($urandom_range(0, 1));
      step();
    end

    // reset in the middle of traffic, then first push after release
    idle_inputs();
    push_pc(32'h600); step();
    push_pc(32'h604); step();
    do_reset();
    push_pc(32'h300); step();
    idle_inputs(); #1;
    check("post_rst_pc", pc[1], 32'h300);
    check("post_rst_count", cnt[1], 1);
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
